rt8_err_mon: RTL and testbench



---
 rtl/rt8_pkg.sv | 15 +
 rtl/sat_cnt.sv | 35 +++
 rtl/rt8_err_mon.sv | 129 ++++++++++++
 tb/tb_rt8_err_mon.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rt8_pkg.sv
// Shared definitions for the rt8 error monitor: FSM state encoding and the
// bit positions of each compressor inside the registered error vector.
package rt8_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_e;

  localparam int ERR_U0 = 2;
  localparam int ERR_U1 = 1;
  localparam int ERR_U2 = 0;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear; sat_hit flags an increment
// attempted while the counter already holds its maximum value.
module sat_cnt #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         sat_hit
);

  logic [W-1:0] r_q;
  logic         w_at_max;

  assign w_at_max = &r_q;

  // Count register: clear wins over increment, increments stop at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en && !w_at_max) begin
      r_q <= r_q + W'(1);
    end else begin
      r_q <= r_q;
    end
  end

  assign q       = r_q;
  assign sat_hit = en & w_at_max;

endmodule

// File: rtl/rt8_err_mon.sv
// Windowed error-statistics monitor for the rt8 approximate compressor tree.
// Optional first-error index capture is built when RT8_ERR_MON_FIRST_IDX_EN is defined.
module rt8_err_mon
  import rt8_pkg::*;
#(
  parameter int WIN_W = 16,
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [2:0]       err_in,
  input  logic             err_any,
  input  logic             start,
  input  logic [WIN_W-1:0] window_len,
  output logic             busy,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_cnt0,
  output logic [CNT_W-1:0] rpt_cnt1,
  output logic [CNT_W-1:0] rpt_cnt2,
  output logic [CNT_W-1:0] rpt_any,
  output logic             rpt_sat,
  output logic [WIN_W-1:0] rpt_first_idx,
  output logic             rpt_first_vld
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIN_W-1:0] r_len;
  logic [WIN_W-1:0] r_idx;
  logic             r_sat;
  logic             r_busy;
  logic             r_rpt_valid;
  logic             w_start_ok;
  logic             w_smp;
  logic             w_last;
  logic [3:0]       w_en;
  logic [3:0]       w_hit;

  assign w_start_ok = (r_state == IDLE) && start && (window_len != '0);
  assign w_smp      = (r_state == RUN) && in_valid;
  assign w_last     = w_smp && (r_idx == (r_len - WIN_W'(1)));

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_state_nxt = RUN;    else w_state_nxt = IDLE;
      RUN:     if (w_last)     w_state_nxt = REPORT; else w_state_nxt = RUN;
      REPORT:  if (rpt_ready)  w_state_nxt = IDLE;   else w_state_nxt = REPORT;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register with busy/valid registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_rpt_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != IDLE);
      r_rpt_valid <= (w_state_nxt == REPORT);
    end
  end

  // Window length, sample index and sticky saturation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len <= '0;
      r_idx <= '0;
      r_sat <= 1'b0;
    end else if (w_start_ok) begin
      r_len <= window_len;
      r_idx <= '0;
      r_sat <= 1'b0;
    end else if (w_smp) begin
      r_idx <= r_idx + WIN_W'(1);
      r_sat <= r_sat | (|w_hit);
    end else begin
      r_len <= r_len;
      r_idx <= r_idx;
      r_sat <= r_sat;
    end
  end

  assign w_en = {w_smp & err_in[ERR_U0], w_smp & err_in[ERR_U1],
                 w_smp & err_in[ERR_U2], w_smp & err_any};

  sat_cnt #(.W(CNT_W)) u_cnt0 (.clk(clk), .rst_n(rst_n), .clr(w_start_ok), .en(w_en[3]), .q(rpt_cnt0), .sat_hit(w_hit[3]));
  sat_cnt #(.W(CNT_W)) u_cnt1 (.clk(clk), .rst_n(rst_n), .clr(w_start_ok), .en(w_en[2]), .q(rpt_cnt1), .sat_hit(w_hit[2]));
  sat_cnt #(.W(CNT_W)) u_cnt2 (.clk(clk), .rst_n(rst_n), .clr(w_start_ok), .en(w_en[1]), .q(rpt_cnt2), .sat_hit(w_hit[1]));
  sat_cnt #(.W(CNT_W)) u_cnta (.clk(clk), .rst_n(rst_n), .clr(w_start_ok), .en(w_en[0]), .q(rpt_any),  .sat_hit(w_hit[0]));

  assign busy      = r_busy;
  assign rpt_valid = r_rpt_valid;
  assign rpt_sat   = r_sat;

`ifdef RT8_ERR_MON_FIRST_IDX_EN
  logic [WIN_W-1:0] r_first_idx;
  logic             r_first_vld;

  // Capture only the first err_any sample of the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first_idx <= '0;
      r_first_vld <= 1'b0;
    end else if (w_start_ok) begin
      r_first_idx <= '0;
      r_first_vld <= 1'b0;
    end else if (w_smp && err_any && !r_first_vld) begin
      r_first_idx <= r_idx;
      r_first_vld <= 1'b1;
    end else begin
      r_first_idx <= r_first_idx;
      r_first_vld <= r_first_vld;
    end
  end

  assign rpt_first_idx = r_first_idx;
  assign rpt_first_vld = r_first_vld;
`else
  assign rpt_first_idx = '0;
  assign rpt_first_vld = 1'b0;
`endif

endmodule

// File: tb/tb_rt8_err_mon.sv
// Self-checking bench for rt8_err_mon: directed table, corner sequences and
// random windows against a queue-based reference, on CNT_W=12 and CNT_W=2 instances.
module tb_rt8_err_mon;

  localparam int WIN_W = 16;
  localparam int CNT_A = 12;
  localparam int CNT_B = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [2:0]       err_in = 3'd0;
  logic             err_any = 1'b0;
  logic             start = 1'b0;
  logic [WIN_W-1:0] window_len = '0;
  logic             rpt_ready = 1'b0;

  logic             busy_a, rpt_valid_a, sat_a, fv_a;
  logic [CNT_A-1:0] c0_a, c1_a, c2_a, ca_a;
  logic [WIN_W-1:0] fi_a;
  logic             busy_b, rpt_valid_b, sat_b, fv_b;
  logic [CNT_B-1:0] c0_b, c1_b, c2_b, ca_b;
  logic [WIN_W-1:0] fi_b;

  rt8_err_mon #(.WIN_W(WIN_W), .CNT_W(CNT_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .err_in(err_in), .err_any(err_any),
    .start(start), .window_len(window_len), .busy(busy_a), .rpt_valid(rpt_valid_a),
    .rpt_ready(rpt_ready), .rpt_cnt0(c0_a), .rpt_cnt1(c1_a), .rpt_cnt2(c2_a), .rpt_any(ca_a),
    .rpt_sat(sat_a), .rpt_first_idx(fi_a), .rpt_first_vld(fv_a));

  rt8_err_mon #(.WIN_W(WIN_W), .CNT_W(CNT_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .err_in(err_in), .err_any(err_any),
    .start(start), .window_len(window_len), .busy(busy_b), .rpt_valid(rpt_valid_b),
    .rpt_ready(rpt_ready), .rpt_cnt0(c0_b), .rpt_cnt1(c1_b), .rpt_cnt2(c2_b), .rpt_any(ca_b),
    .rpt_sat(sat_b), .rpt_first_idx(fi_b), .rpt_first_vld(fv_b));

  always #5 clk = ~clk;

  typedef struct {
    int c0; int c1; int c2; int ca; int sat; int fi; int fv;
  } rep_t;

  typedef struct {
    int          len;
    int          gap;
    logic [31:0] smp;   // nibble i = {err_in[2:0], err_any} of sample i
    rep_t        exp;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Reference: count set bits per sample over the window, clip to the counter max.
  function automatic rep_t model(input logic [3:0] q[$], input int mx);
    rep_t r;
    int   raw [4];
    r = '{default: 0};
    for (int b = 0; b < 4; b++) raw[b] = 0;
    for (int i = 0; i < q.size(); i++) begin
      for (int b = 0; b < 4; b++) if (q[i][3-b]) raw[b]++;
      if (q[i][0] && r.fv == 0) begin r.fi = i; r.fv = 1; end
    end
    r.c0 = (raw[0] > mx) ? mx : raw[0];
    r.c1 = (raw[1] > mx) ? mx : raw[1];
    r.c2 = (raw[2] > mx) ? mx : raw[2];
    r.ca = (raw[3] > mx) ? mx : raw[3];
    r.sat = (raw[0] > mx || raw[1] > mx || raw[2] > mx || raw[3] > mx) ? 1 : 0;
`ifndef RT8_ERR_MON_FIRST_IDX_EN
    r.fi = 0; r.fv = 0;
`endif
    return r;
  endfunction

  function automatic vec_t mk(input int len, input int gap, input logic [31:0] smp,
                              input int c0, input int c1, input int c2, input int ca,
                              input int sat, input int fi, input int fv);
    vec_t v;
    v.len = len; v.gap = gap; v.smp = smp;
    v.exp = '{c0: c0, c1: c1, c2: c2, ca: ca, sat: sat, fi: fi, fv: fv};
`ifndef RT8_ERR_MON_FIRST_IDX_EN
    v.exp.fi = 0; v.exp.fv = 0;
`endif
    return v;
  endfunction

  task automatic check_report(input string tag, input rep_t ea, input rep_t eb);
    chk({tag, " a.cnt0"}, 32'(c0_a), ea.c0);
    chk({tag, " a.cnt1"}, 32'(c1_a), ea.c1);
    chk({tag, " a.cnt2"}, 32'(c2_a), ea.c2);
    chk({tag, " a.any"},  32'(ca_a), ea.ca);
    chk({tag, " a.sat"},  32'(sat_a), ea.sat);
    chk({tag, " a.first_idx"}, 32'(fi_a), ea.fi);
    chk({tag, " a.first_vld"}, 32'(fv_a), ea.fv);
    chk({tag, " b.cnt0"}, 32'(c0_b), eb.c0);
    chk({tag, " b.cnt1"}, 32'(c1_b), eb.c1);
    chk({tag, " b.cnt2"}, 32'(c2_b), eb.c2);
    chk({tag, " b.any"},  32'(ca_b), eb.ca);
    chk({tag, " b.sat"},  32'(sat_b), eb.sat);
    chk({tag, " b.first_idx"}, 32'(fi_b), eb.fi);
    chk({tag, " b.first_vld"}, 32'(fv_b), eb.fv);
  endtask

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic send(input logic [3:0] s);
    {err_in, err_any} = s;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    {err_in, err_any} = 4'($urandom_range(0, 15));
  endtask

  task automatic run_window(input string tag, input logic [3:0] q[$], input int gap,
                            input int hold, input bit poke, input rep_t ea, input rep_t eb);
    start = 1'b1; window_len = WIN_W'(q.size());
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy at start"}, 32'(busy_a), 1);
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
          chk({tag, " busy in gap"}, 32'(busy_a), 1);
        end
      end
      chk({tag, " rpt_valid early"}, 32'(rpt_valid_a), 0);
      send(q[i]);
    end
    chk({tag, " rpt_valid after last"}, 32'(rpt_valid_a), 1);
    chk({tag, " b.rpt_valid after last"}, 32'(rpt_valid_b), 1);
    check_report(tag, ea, eb);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1));
      start = poke && (h == hold / 2);
      window_len = WIN_W'(3);
      @(posedge clk); #1;
      chk({tag, " rpt_valid held"}, 32'(rpt_valid_a), 1);
      chk({tag, " a.cnt0 held"}, 32'(c0_a), ea.c0);
      chk({tag, " a.any held"}, 32'(ca_a), ea.ca);
    end
    in_valid = 1'b0; start = 1'b0;
    if (hold > 0) check_report({tag, " after hold"}, ea, eb);
    rpt_ready = 1'b1;
    @(posedge clk); #1;
    rpt_ready = 1'b0;
    chk({tag, " rpt_valid after accept"}, 32'(rpt_valid_a), 0);
    chk({tag, " busy after accept"}, 32'(busy_a), 0);
    check_report({tag, " kept"}, ea, eb);
    if (poke) begin
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        chk({tag, " start dropped"}, 32'(busy_a), 0);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vt [6];
    logic [3:0]  q [$];
    rep_t        ea, eb;

    vt[0] = mk(4, 0, 32'h0000_5F09, 2, 2, 1, 3, 0, 0, 1);
    vt[1] = mk(4, 3, 32'h0000_5F09, 2, 2, 1, 3, 0, 0, 1);
    vt[2] = mk(6, 0, 32'h00FF_FFFF, 6, 6, 6, 6, 0, 0, 1);
    vt[3] = mk(3, 0, 32'h0000_0410, 0, 1, 0, 1, 0, 1, 1);
    vt[4] = mk(2, 1, 32'h0000_0062, 0, 1, 2, 0, 0, 0, 0);
    vt[5] = mk(8, 1, 32'h1818_1818, 4, 0, 0, 4, 0, 1, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy_a), 0);
    chk("reset rpt_valid", 32'(rpt_valid_a), 0);
    chk("reset cnt0", 32'(c0_a), 0);
    chk("reset any", 32'(ca_a), 0);
    chk("reset sat", 32'(sat_a), 0);
    chk("reset first_vld", 32'(fv_a), 0);
    rst_n = 1'b1;
    in_valid = 1'b1; err_in = 3'b111; err_any = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("idle in_valid ignored", 32'(c0_a), 0);

    for (int v = 0; v < 6; v++) begin
      q.delete();
      for (int i = 0; i < vt[v].len; i++) q.push_back(vt[v].smp[4*i +: 4]);
      run_window($sformatf("vec%0d", v), q, vt[v].gap, 0, 1'b0, vt[v].exp, model(q, 3));
    end

    // Report held for 10 cycles with a start pulse that must be dropped.
    q = '{4'b1001, 4'b0110};
    run_window("hold", q, 0, 10, 1'b1, model(q, 4095), model(q, 3));

    // Zero-length window is ignored.
    start = 1'b1; window_len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("len0 busy", 32'(busy_a), 0);
      chk("len0 rpt_valid", 32'(rpt_valid_a), 0);
      @(posedge clk); #1;
    end

    // Reset after 2 of 5 samples aborts the window.
    start = 1'b1; window_len = WIN_W'(5);
    @(posedge clk); #1;
    start = 1'b0;
    send(4'b1111);
    send(4'b1111);
    rst_n = 1'b0;
    #2;
    chk("abort busy", 32'(busy_a), 0);
    chk("abort rpt_valid", 32'(rpt_valid_a), 0);
    chk("abort cnt0", 32'(c0_a), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("abort no report", 32'(rpt_valid_a), 0);
    end
    q = '{4'b0011};
    ea = model(q, 4095);
    chk("abort-follow model cnt2", 32'(ea.c2), 1);
    run_window("after abort", q, 0, 2, 1'b0, ea, model(q, 3));

    // Random windows against the reference.
    for (int r = 0; r < 20; r++) begin
      int len;
      len = $urandom_range(1, 12);
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(4'($urandom_range(0, 15)));
      run_window($sformatf("rnd%0d", r), q, $urandom_range(0, 2), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), model(q, 4095), model(q, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
